// File: rtl/sm3_msg_gntr_if.sv
// Beat bus from the SM3 message generator to the hash core.
interface sm3_msg_gntr_if #(
  parameter int INPT_DW = 32
);
  logic [INPT_DW-1:0]   msg_inpt_d;
  logic [INPT_DW/8-1:0] msg_inpt_vld_byte;
  logic                 msg_inpt_vld;
  logic                 msg_inpt_lst;
  logic                 msg_inpt_rdy;

  modport master (
    output msg_inpt_d,
    output msg_inpt_vld_byte,
    output msg_inpt_vld,
    output msg_inpt_lst,
    input  msg_inpt_rdy
  );

  modport slave (
    input  msg_inpt_d,
    input  msg_inpt_vld_byte,
    input  msg_inpt_vld,
    input  msg_inpt_lst,
    output msg_inpt_rdy
  );
endinterface

// File: rtl/sm3_msg_gntr.sv
// SM3 test-message generator: emits ceil(byte_num/BPW) pattern beats.
// Define SM3_MSG_GNTR_INCR_EN to add the incrementing-data adder.
module sm3_msg_gntr #(
  parameter  int INPT_DW = 32,
  localparam int BPW     = INPT_DW / 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [60:0]        byte_num,
  input  logic [INPT_DW-1:0] pttrn,
  input  logic               incr_mode,
  sm3_msg_gntr_if.master     msg,
  output logic               busy,
  output logic               done,
  output logic               err
);
  localparam int SH = $clog2(BPW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]         state;
  logic [INPT_DW-1:0] pttrn_reg;
  logic [57:0]        beat_cnt;
  logic [SH-1:0]      rem;
  logic [61:0]        sum;
  logic [INPT_DW-1:0] raw;
  logic [INPT_DW-1:0] dmask;
  logic [BPW-1:0]     lmask;
  logic [BPW-1:0]     vb;
  logic               vld;
  logic               last;
  logic               xfer;
  logic               idle;
  logic               acpt;

  // FIN is not busy, so a start in the done cycle is taken
  assign idle = state != SEND;
  assign acpt = idle && start && byte_num != '0;
  assign vld  = state == SEND;
  assign last = beat_cnt == 58'd1;
  assign xfer = vld && msg.msg_inpt_rdy;
  assign sum  = {1'b0, byte_num} + 62'(BPW - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pttrn_reg <= '0;
      beat_cnt  <= '0;
      rem       <= '0;
      err       <= 1'b0;
    end else begin
      err <= idle && start && byte_num == '0;
      case (state)
        SEND: begin
          if (xfer) begin
            beat_cnt <= beat_cnt - 58'd1;
            if (last) state <= FIN;
          end
        end
        default: begin
          state <= acpt ? SEND : IDLE;
          if (acpt) begin
            pttrn_reg <= pttrn;
            beat_cnt  <= sum[SH +: 58];
            rem       <= byte_num[SH-1:0];
          end
        end
      endcase
    end
  end

`ifdef SM3_MSG_GNTR_INCR_EN
  logic               incr_reg;
  logic [INPT_DW-1:0] beat_idx;
  logic               unused_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      incr_reg <= 1'b0;
      beat_idx <= '0;
    end else if (acpt) begin
      incr_reg <= incr_mode;
      beat_idx <= '0;
    end else if (xfer) begin
      beat_idx <= beat_idx + INPT_DW'(1);
    end
  end

  assign raw         = incr_reg ? pttrn_reg + beat_idx : pttrn_reg;
  assign unused_bits = ^{sum[SH-1:0], sum[61:SH+58]};
`else
  logic unused_bits;

  assign raw         = pttrn_reg;
  assign unused_bits = ^{incr_mode, sum[SH-1:0], sum[61:SH+58]};
`endif

  // Final-beat mask keeps the first rem bytes (MSB first)
  always_comb begin
    lmask = (rem == '0) ? '1 : ~({BPW{1'b1}} >> rem);
    vb    = '0;
    if (vld) vb = last ? lmask : '1;
    dmask = '0;
    for (int b = 0; b < BPW; b++)
      dmask[INPT_DW-1-8*b -: 8] = {8{vb[BPW-1-b]}};
  end

  assign msg.msg_inpt_vld      = vld;
  assign msg.msg_inpt_lst      = vld && last;
  assign msg.msg_inpt_vld_byte = vb;
  assign msg.msg_inpt_d        = vld ? (raw & dmask) : pttrn_reg;

  assign busy = vld;
  assign done = state == FIN;
endmodule
